// File: rtl/output_squeezer_if.sv
// Output word stream of the squeeze controller: 64-bit words with a last flag
// and the valid-bit count of the final word, under valid/ready flow control.
interface output_squeezer_if #(
  parameter int LANE_BITS = 64
);
  localparam int SIZE_W = $clog2(LANE_BITS);

  logic [LANE_BITS-1:0] dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 dout_last;
  logic [SIZE_W-1:0]    dout_size;

  modport master (
    output dout,
    output dout_valid,
    output dout_last,
    output dout_size,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    input  dout_last,
    input  dout_size,
    output dout_ready
  );
endinterface

// File: rtl/output_squeezer.sv
// Squeeze-side controller for the Keccak core: streams rate lanes as output
// words, tracks the remaining length and requests permutations between blocks.
module output_squeezer #(
  parameter int WIDTH     = 32,
  parameter int LANE_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     out_size,
  input  logic [4:0]           rate_words,
  output logic [4:0]           lane_idx,
  input  logic [LANE_BITS-1:0] lane_data,
  output logic                 perm_req,
  input  logic                 perm_done,
  output logic                 busy,
  output logic                 done,
  output_squeezer_if.master    dout_if
);

  localparam int SIZE_W = $clog2(LANE_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_REQ,
    S_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   remaining_q, remaining_d;
  logic [4:0]         rate_q, rate_d;
  logic [4:0]         lane_idx_q, lane_idx_d;
  logic               done_q, done_d;

  logic               emit;
  logic               last;
  logic [SIZE_W-1:0]  size;
  logic [LANE_BITS-1:0] mask;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      rate_q      <= '0;
      lane_idx_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      rate_q      <= rate_d;
      lane_idx_q  <= lane_idx_d;
      done_q      <= done_d;
    end
  end

  // A size of zero on the last word means the whole lane is valid.
  always_comb begin
    emit = (state_q == S_EMIT);
    last = emit && (remaining_q <= WIDTH'(LANE_BITS));
    size = last ? remaining_q[SIZE_W-1:0] : '0;
    mask = '1;
    for (int i = 0; i < LANE_BITS; i++) begin
      mask[i] = (size == '0) || (i < int'(size));
    end
    dout_if.dout       = emit ? (lane_data & (last ? mask : '1)) : '0;
    dout_if.dout_valid = emit;
    dout_if.dout_last  = last;
    dout_if.dout_size  = size;
    lane_idx = lane_idx_q;
    perm_req = (state_q == S_REQ);
    busy     = (state_q != S_IDLE);
    done     = done_q;
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    rate_d      = rate_q;
    lane_idx_d  = lane_idx_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (out_size != '0) begin
            remaining_d = out_size;
            rate_d      = rate_words;
            lane_idx_d  = '0;
            state_d     = S_EMIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_EMIT: begin
        // The last-word test comes first, so the subtract below never wraps.
        if (dout_if.dout_ready) begin
          if (last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            remaining_d = remaining_q - WIDTH'(LANE_BITS);
            if (lane_idx_q == rate_q - 5'd1) begin
              lane_idx_d = '0;
              state_d    = S_REQ;
            end else begin
              lane_idx_d = lane_idx_q + 5'd1;
            end
          end
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (perm_done) begin
          state_d = S_EMIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_output_squeezer.sv
// Directed bench for output_squeezer: hashes of several lengths and rates,
// backpressure, zero length and reset while waiting on a permutation.
module tb_output_squeezer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] out_size;
  logic [4:0]  rate_words;
  logic [4:0]  lane_idx;
  logic [63:0] lane_data;
  logic        perm_req;
  logic        perm_done;
  logic        busy;
  logic        done;

  int check_count;
  int error_count;
  int perm_cnt;

  output_squeezer_if #(.LANE_BITS(64)) sq_if ();

  output_squeezer #(.WIDTH(32), .LANE_BITS(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .out_size   (out_size),
    .rate_words (rate_words),
    .lane_idx   (lane_idx),
    .lane_data  (lane_data),
    .perm_req   (perm_req),
    .perm_done  (perm_done),
    .busy       (busy),
    .done       (done),
    .dout_if    (sq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each lane carries its index and the number of permutations done so far.
  function automatic logic [63:0] lanePattern(input int perm, input int lane);
    logic [31:0] p;
    logic [31:0] l;
    p = perm;
    l = lane;
    return {p[7:0], 24'hC0FFEE, 3'b101, 24'h123456, l[4:0]};
  endfunction

  assign lane_data = lanePattern(perm_cnt, int'(lane_idx));

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int osize, input int rate);
    start      = 1'b1;
    out_size   = 32'(osize);
    rate_words = 5'(rate);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic runSqueeze(input string name, input int osize, input int rate,
                            input bit rand_ready, input int exp_words,
                            input int exp_perms, input int exp_size);
    int          words;
    int          perms;
    int          pd_timer;
    int          cycles;
    bit          finished;
    bit          is_last;
    bit          prev_stall;
    logic [63:0] exp_word;
    logic [63:0] prev_dout;
    logic        prev_last;
    logic [5:0]  prev_size;
    logic [4:0]  prev_lane;
    words = 0; perms = 0; pd_timer = -1; cycles = 0;
    finished = 1'b0; prev_stall = 1'b0;
    prev_dout = '0; prev_last = 1'b0; prev_size = '0; prev_lane = '0;
    perm_cnt = 0;
    perm_done = 1'b0;
    sq_if.dout_ready = rand_ready ? 1'b0 : 1'b1;
    applyStimulus(osize, rate);
    checkOutput({name, "_first_valid"}, 64'(sq_if.dout_valid), 64'd1);
    while (!finished && cycles < 4000) begin
      perm_done = 1'b0;
      if (pd_timer > 0) begin
        pd_timer--;
        if (pd_timer == 0) begin
          perm_done = 1'b1;
          perm_cnt++;
          pd_timer = -1;
        end
      end
      if (perm_req) begin
        perms++;
        pd_timer = 24;
      end
      if (pd_timer > 0) checkOutput({name, "_wait_valid"}, 64'(sq_if.dout_valid), 64'd0);
      sq_if.dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) begin
        checkOutput({name, "_stall_dout"}, sq_if.dout, prev_dout);
        checkOutput({name, "_stall_last"}, 64'(sq_if.dout_last), 64'(prev_last));
        checkOutput({name, "_stall_size"}, 64'(sq_if.dout_size), 64'(prev_size));
        checkOutput({name, "_stall_lane"}, 64'(lane_idx), 64'(prev_lane));
      end
      if (sq_if.dout_valid && sq_if.dout_ready) begin
        is_last  = (words == exp_words - 1);
        exp_word = lanePattern(words / rate, words % rate);
        if (is_last && exp_size != 0) exp_word = exp_word & ((64'd1 << exp_size) - 64'd1);
        checkOutput($sformatf("%s_w%0d_lane", name, words), 64'(lane_idx), 64'(words % rate));
        checkOutput($sformatf("%s_w%0d_data", name, words), sq_if.dout, exp_word);
        checkOutput($sformatf("%s_w%0d_last", name, words), 64'(sq_if.dout_last), 64'(is_last));
        checkOutput($sformatf("%s_w%0d_size", name, words), 64'(sq_if.dout_size),
                    is_last ? 64'(exp_size) : 64'd0);
        words++;
        if (is_last) finished = 1'b1;
      end
      prev_stall = sq_if.dout_valid && !sq_if.dout_ready;
      prev_dout  = sq_if.dout;
      prev_last  = sq_if.dout_last;
      prev_size  = sq_if.dout_size;
      prev_lane  = lane_idx;
      @(negedge clk);
      cycles++;
    end
    perm_done = 1'b0;
    if (!finished) begin
      checkOutput({name, "_timeout"}, 64'd1, 64'd0);
    end else begin
      checkOutput({name, "_done"}, 64'(done), 64'd1);
      checkOutput({name, "_busy_end"}, 64'(busy), 64'd0);
      checkOutput({name, "_valid_end"}, 64'(sq_if.dout_valid), 64'd0);
    end
    checkOutput({name, "_words"}, 64'(words), 64'(exp_words));
    checkOutput({name, "_perms"}, 64'(perms), 64'(exp_perms));
  endtask

  initial begin
    int cnt;
    check_count = 0;
    error_count = 0;
    perm_cnt    = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    out_size    = '0;
    rate_words  = '0;
    perm_done   = 1'b0;
    sq_if.dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", 64'(sq_if.dout_valid), 64'd0);
    checkOutput("reset_dout", sq_if.dout, 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_perm_req", 64'(perm_req), 64'd0);
    checkOutput("reset_lane", 64'(lane_idx), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    runSqueeze("sha3_256", 256, 17, 1'b0, 4, 0, 0);
    runSqueeze("sha3_224", 224, 18, 1'b0, 4, 0, 32);
    runSqueeze("shake128", 1600, 21, 1'b0, 25, 1, 0);
    runSqueeze("shake128_rnd", 1600, 21, 1'b1, 25, 1, 0);
    runSqueeze("rate_mult", 1088, 17, 1'b0, 17, 0, 0);

    applyStimulus(0, 17);
    checkOutput("zero_done", 64'(done), 64'd1);
    checkOutput("zero_valid", 64'(sq_if.dout_valid), 64'd0);
    checkOutput("zero_busy", 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput("zero_done_pulse", 64'(done), 64'd0);

    perm_cnt = 0;
    sq_if.dout_ready = 1'b1;
    applyStimulus(1600, 21);
    cnt = 0;
    while (!perm_req && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("rst_reach_req", 64'(perm_req), 64'd1);
    @(negedge clk);
    checkOutput("rst_wait_busy", 64'(busy), 64'd1);
    rst_n     = 1'b0;
    perm_done = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_valid", 64'(sq_if.dout_valid), 64'd0);
    checkOutput("rst_mid_last", 64'(sq_if.dout_last), 64'd0);
    checkOutput("rst_mid_size", 64'(sq_if.dout_size), 64'd0);
    checkOutput("rst_mid_dout", sq_if.dout, 64'd0);
    checkOutput("rst_mid_perm_req", 64'(perm_req), 64'd0);
    checkOutput("rst_mid_busy", 64'(busy), 64'd0);
    checkOutput("rst_mid_done", 64'(done), 64'd0);
    checkOutput("rst_mid_lane", 64'(lane_idx), 64'd0);
    rst_n     = 1'b1;
    perm_done = 1'b0;
    @(negedge clk);
    checkOutput("rst_after_busy", 64'(busy), 64'd0);
    checkOutput("rst_after_valid", 64'(sq_if.dout_valid), 64'd0);

    runSqueeze("restart", 256, 17, 1'b0, 4, 0, 0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/output_squeezer.md
# output_squeezer

Squeeze-side output controller for the Keccak core, the output-side counterpart of the absorb-side input size counter. After the final absorb permutation it reads rate lanes from the state, streams them as 64-bit words over a valid/ready interface, and tracks the remaining output length. It flags the last word and its valid-bit count, and requests extra permutations when the requested length (SHAKE) exceeds one rate block.

## Interface
- `WIDTH`, 32: width of the output-length field in bits.
- `LANE_BITS`, 64: lane/word width; `$clog2(LANE_BITS)` sets the width of `dout_size`.
- `clk` input 1: clock; all logic on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start` input 1: one-cycle pulse; loads `out_size` and `rate_words`; honored only in IDLE.
- `out_size` input WIDTH: requested output length in bits.
- `rate_words` input 5: lanes per rate block (17 SHA3-256, 21 SHAKE128, 9 SHA3-512); valid range 1..21.
- `lane_idx` output 5: index of the state lane being read.
- `lane_data` input 64: state lane at `lane_idx`, combinational.
- `perm_req` output 1: one-cycle pulse requesting one permutation.
- `perm_done` input 1: one-cycle pulse when the requested permutation completes.
- `dout` output 64: output word, LSB-first; bits above the valid count are zeroed on the last word.
- `dout_valid` output 1: `dout` is valid.
- `dout_ready` input 1: sink accepts the word.
- `dout_last` output 1: current word is the final word.
- `dout_size` output `$clog2(LANE_BITS)`: on the last word, `remaining[5:0]`; 0 encodes a full 64 bits. Otherwise 0.
- `busy` output 1: high in any state except IDLE.
- `done` output 1: one-cycle pulse when the squeeze completes.

## Operation
- Registers:
  - `remaining[WIDTH-1:0]`.
  - `rate_r[4:0]`.
  - `lane_idx[4:0]`.
  - FSM with states IDLE, EMIT, REQ, WAIT.
- IDLE:
  - On `start` with `out_size != 0`: load `remaining=out_size`, `rate_r=rate_words`, `lane_idx=0`, then go to EMIT.
  - On `start` with `out_size == 0`: pulse `done` next cycle and stay in IDLE.
- EMIT:
  - `dout_valid=1`; `dout` = `lane_data`, masked to `dout_size` bits when `dout_last`.
  - `dout_last = (remaining <= 64)`.
  - Handshake when `dout_valid & dout_ready`:
    - If `dout_last`: go to IDLE and pulse `done`.
    - Otherwise `remaining -= 64`.
    - If `lane_idx == rate_r-1` (and not last): `lane_idx=0`, go to REQ.
    - Otherwise `lane_idx++`.
- REQ: `perm_req=1` for exactly one cycle, then go to WAIT.
- WAIT:
  - `dout_valid=0`.
  - On `perm_done`, go to EMIT.
  - `perm_done` outside WAIT is ignored.
- Arithmetic:
  - `remaining` is an unsigned subtract that never underflows, because the last test precedes any decrement.
  - `lane_idx` never exceeds `rate_r-1`.
- Boundary: when the last word falls exactly on the rate boundary (`out_size = k*64*rate`), the squeeze ends with no `perm_req`.
- `start` while `busy` is ignored; `out_size`/`rate_words` are sampled only on an accepted `start`.
- `rst_n` low at any point, including mid-emission or in WAIT:
  - Next edge returns to IDLE.
  - All registers clear.
  - A pending `perm_done` is dropped.
- Reset values:
  - `dout_valid`, `dout_last`, `perm_req`, `busy`, `done` = 0.
  - `lane_idx`, `dout_size` = 0.
  - `dout` = 0, because it is masked when not valid.

## Timing
- `start` sampled at edge t gives `dout_valid` high from cycle t+1.
- Throughput is one word per cycle while `dout_ready` is high.
- Backpressure: while `dout_valid & !dout_ready`, `dout`, `dout_last`, `dout_size` and `lane_idx` stay stable. The core holds state during squeeze.
- Rate boundary: handshake at edge t gives `perm_req` high in cycle t+1 and WAIT from t+2.
  - `perm_done` sampled at edge u gives `dout_valid` at u+1.
  - Earliest legal `perm_done` is the first cycle of WAIT.
- Final handshake at edge t: `done` high in cycle t+1, `busy` low in cycle t+1.
- A `start` in the `done` cycle is accepted.

## Test plan
- SHA3-256: `out_size=256`, `rate_words=17`, ready tied high.
  - Exactly 4 words, lanes 0..3.
  - `dout_last` on word 4 with `dout_size=0`.
  - `done` one cycle later; `perm_req` never asserted.
- SHA3-224: `out_size=224`, `rate_words=18`.
  - 4 words; word 4 has `dout_size=32` and `dout[63:32]=0`.
- SHAKE128: `out_size=1600`, `rate_words=21`.
  - 21 words, then `perm_req` pulse; drive `perm_done` 24 cycles later.
  - Then 4 more words from lane 0, last with `dout_size=0`; exactly one `perm_req` in total.
- Exact rate multiple: `out_size=1088`, `rate_words=17`.
  - 17 words, last on lane 16, no `perm_req`.
- Zero length: `out_size=0` gives no `dout_valid` and a `done` pulse next cycle.
- Random `dout_ready` (about 50%) on the SHAKE128 case: words identical to the ready-high run and held stable under stall.
- Mid-run reset: `rst_n=0` during the WAIT state, with `perm_done` asserted in the same cycle.
  - All outputs are 0 next cycle.
  - A following `start` restarts from lane 0.
